traffic_gen_cfg_master: RTL and testbench
=========================================

// Module: traffic_gen_cfg_master
// PURPOSE
//  Initiator side of the HWPE peripheral config port: programs one traffic_gen job autonomously.
//  On start: acquires a context, writes N_PARAMS job registers, triggers, waits for completion event.
//  Sits between a local sequencer/testbench driver and the accelerator's hwpe_ctrl_slave port.
//  Replaces core-driven register pokes for self-running traffic scenarios.
// PARAMETERS
//  N_PARAMS    16        number of job parameter words written (offsets 0x40 + 4*i)
//  ID_WIDTH    10        width of periph id / r_id
//  MASTER_ID   1         id tag driven on every request; responses with other r_id ignored
//  BASE_ADDR   32'h0     base address of accelerator register space
//  BACKOFF_CYC 8         idle cycles between failed ACQUIRE retries (>=1)
//  TIMEOUT_CYC 65535     max cycles in WAIT_EVT before error; 0 = no timeout
// PORTS
//  clk_i            in   1             clock
//  rst_i            in   1             synchronous reset, active-high
//  start_i          in   1             start job (sampled in IDLE only)
//  params_i         in   N_PARAMS*32   job params, word i = params_i[32*i+:32]; latched on start
//  evt_i            in   1             accelerator job-done event (core 0 evt bit)
//  busy_o           out  1             high from start accept until done/error pulse
//  done_o           out  1             1-cycle pulse: job completed
//  error_o          out  1             1-cycle pulse: timeout in WAIT_EVT
//  job_id_o         out  8             context id returned by ACQUIRE, valid with done_o
//  periph_req_o     out  1             request
//  periph_gnt_i     in   1             grant
//  periph_add_o     out  32            address
//  periph_wen_o     out  1             1 = read, 0 = write
//  periph_be_o      out  4             byte enable, always 4'hF
//  periph_data_o    out  32            write data
//  periph_id_o      out  ID_WIDTH      request id (= MASTER_ID)
//  periph_r_data_i  in   32            read data
//  periph_r_valid_i in   1             response valid (reads and writes)
//  periph_r_id_i    in   ID_WIDTH      response id
// BEHAVIOUR
//  Register offsets: TRIGGER 0x00, ACQUIRE 0x04, STATUS 0x0C, params 0x40+4*i (word addressed).
//  Reset: all outputs 0, periph_be_o=4'hF, periph_id_o=MASTER_ID, FSM IDLE, counters 0.
//  Handshake: req/add/wen/data held stable from assert until req&&gnt; req drops next cycle.
//  Exactly one outstanding transaction; next req only after r_valid with r_id==MASTER_ID.
//  States: IDLE -> ACQ -> ACQ_RSP -> (BACKOFF -> ACQ) | WR -> WR_RSP -> ... -> TRIG -> TRIG_RSP
//    -> WAIT_EVT -> IDLE.
//  IDLE: start_i=1 latches params_i, busy_o=1 next cycle, enter ACQ (req asserted same cycle as entry).
//  ACQ: read BASE+0x04. ACQ_RSP: r_data==32'hFFFF_FFFF (no free context) -> BACKOFF;
//    else job_id_o<=r_data[7:0], param index<=0, WR.
//  BACKOFF: count BACKOFF_CYC idle cycles, then ACQ; retries unbounded.
//  WR: write param[idx] to BASE+0x40+4*idx; after response idx++; idx==N_PARAMS-1 done -> TRIG.
//  TRIG: write 0 to BASE+0x00; after response -> WAIT_EVT, timeout counter cleared.
//  WAIT_EVT: evt_i=1 -> done_o pulse, busy_o=0 same cycle as pulse, -> IDLE.
//    TIMEOUT_CYC!=0 and counter reaches TIMEOUT_CYC-1 without evt -> error_o pulse, -> IDLE.
//    evt_i in same cycle as timeout expiry: done wins (no error).
//  evt_i outside WAIT_EVT ignored; start_i while busy ignored.
//  r_valid before gnt, or with wrong r_id: ignored, no state change.
//  gnt and r_valid of same transaction may not coincide; r_valid earliest one cycle after gnt.
//  Address arithmetic modulo 2^32; idx width $clog2(N_PARAMS)+1.
//  rst_i mid-transaction: req drops next edge, FSM IDLE, no done/error pulse; late responses ignored.
//  Best case latency start->TRIG granted: 2*(N_PARAMS+2) cycles with gnt always high, r_valid +1.
// TESTING
//  1 Slave gnt=1, r_valid 1 cycle later, ACQUIRE returns 0x3, N_PARAMS=16 -> 1 read, 16 writes
//    to 0x40..0x7C with params_i words in order, write 0 to 0x00; evt after 20 cyc -> done_o, job_id_o=3.
//  2 ACQUIRE returns 0xFFFFFFFF twice then 0x1 -> 3 reads spaced by >=8 idle cycles, then normal flow.
//  3 Random gnt stalls (0-5 cycles): add/data/wen stable while req&&!gnt; never 2 outstanding.
//  4 TIMEOUT_CYC=100, no evt -> error_o pulse exactly 100 cycles after TRIG response, busy_o falls.
//  5 rst_i asserted during param write 5 -> req=0 next cycle, busy_o=0, no pulses; restart completes.
//  6 Stray r_valid with r_id!=MASTER_ID and evt_i pulse during WR -> ignored, sequence unchanged.

Source files
------------

// File: rtl/traffic_gen_cfg_master.sv
// Config-port initiator that programs one traffic_gen job on its own:
// acquire a context, write the job parameters, trigger, then wait for the done event.
module traffic_gen_cfg_master #(
  parameter int          N_PARAMS    = 16,
  parameter int          ID_WIDTH    = 10,
  parameter int          MASTER_ID   = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          BACKOFF_CYC = 8,
  parameter int          TIMEOUT_CYC = 65535
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [N_PARAMS*32-1:0] params_i,
  input  logic                  evt_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [7:0]            job_id_o,
  output logic                  periph_req_o,
  input  logic                  periph_gnt_i,
  output logic [31:0]           periph_add_o,
  output logic                  periph_wen_o,
  output logic [3:0]            periph_be_o,
  output logic [31:0]           periph_data_o,
  output logic [ID_WIDTH-1:0]   periph_id_o,
  input  logic [31:0]           periph_r_data_i,
  input  logic                  periph_r_valid_i,
  input  logic [ID_WIDTH-1:0]   periph_r_id_i,
  output logic [3:0]            dbg_state_o
);

  localparam int IW = $clog2(N_PARAMS) + 1;
  localparam int AW = (N_PARAMS > 1) ? $clog2(N_PARAMS) : 1;
  localparam int BW = $clog2(BACKOFF_CYC) + 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [31:0] TRIG_OFF  = 32'h00;
  localparam logic [31:0] ACQ_OFF   = 32'h04;
  localparam logic [31:0] PARAM_OFF = 32'h40;

  typedef enum logic [3:0] {
    S_IDLE, S_ACQ, S_ACQ_RSP, S_BACKOFF, S_WR, S_WR_RSP, S_TRIG, S_TRIG_RSP, S_WAIT_EVT
  } state_t;

  state_t         state, state_nx;
  logic [IW-1:0]  idx;
  logic [BW-1:0]  bo_cnt;
  logic [TW-1:0]  to_cnt;
  logic [7:0]     job_id_q;
  logic           done_q, error_q;
  logic [31:0]    params_q [N_PARAMS];

  logic rsp_ok, acq_fail, last_param, bo_done, to_hit;

  // Handshake: a request (req/add/wen/data) is held until req&&gnt, req drops the
  // next cycle, and the following request waits for r_valid carrying MASTER_ID.
  assign rsp_ok     = periph_r_valid_i && (periph_r_id_i == ID_WIDTH'(MASTER_ID));
  assign acq_fail   = (periph_r_data_i == 32'hFFFF_FFFF);
  assign last_param = (idx == IW'(N_PARAMS - 1));
  assign bo_done    = (bo_cnt == BW'(BACKOFF_CYC - 1));
  assign to_hit     = (TIMEOUT_CYC != 0) && (to_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (start_i) state_nx = S_ACQ;
      S_ACQ:      if (periph_gnt_i) state_nx = S_ACQ_RSP;
      S_ACQ_RSP:  if (rsp_ok) state_nx = acq_fail ? S_BACKOFF : S_WR;
      S_BACKOFF:  if (bo_done) state_nx = S_ACQ;
      S_WR:       if (periph_gnt_i) state_nx = S_WR_RSP;
      S_WR_RSP:   if (rsp_ok) state_nx = last_param ? S_TRIG : S_WR;
      S_TRIG:     if (periph_gnt_i) state_nx = S_TRIG_RSP;
      S_TRIG_RSP: if (rsp_ok) state_nx = S_WAIT_EVT;
      S_WAIT_EVT: if (evt_i || to_hit) state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  // Pulses are registered so they land in the first IDLE cycle, where busy is already low.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx      <= '0;
      bo_cnt   <= '0;
      to_cnt   <= '0;
      job_id_q <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      for (int i = 0; i < N_PARAMS; i++) params_q[i] <= '0;
    end else begin
      done_q  <= (state == S_WAIT_EVT) && evt_i;
      error_q <= (state == S_WAIT_EVT) && !evt_i && to_hit;
      case (state)
        S_IDLE: if (start_i)
          for (int i = 0; i < N_PARAMS; i++) params_q[i] <= params_i[32*i +: 32];
        S_ACQ_RSP: begin
          bo_cnt <= '0;
          if (rsp_ok && !acq_fail) begin
            job_id_q <= periph_r_data_i[7:0];
            idx      <= '0;
          end
        end
        S_BACKOFF:  bo_cnt <= bo_cnt + BW'(1);
        S_WR_RSP:   if (rsp_ok && !last_param) idx <= idx + IW'(1);
        S_TRIG_RSP: to_cnt <= '0;
        S_WAIT_EVT: to_cnt <= to_cnt + TW'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    periph_req_o  = 1'b0;
    periph_add_o  = '0;
    periph_wen_o  = 1'b0;
    periph_data_o = '0;
    case (state)
      S_ACQ: begin
        periph_req_o = 1'b1;
        periph_add_o = BASE_ADDR + ACQ_OFF;
        periph_wen_o = 1'b1;
      end
      S_WR: begin
        periph_req_o  = 1'b1;
        periph_add_o  = BASE_ADDR + PARAM_OFF + 32'({idx, 2'b00});
        periph_data_o = params_q[idx[AW-1:0]];
      end
      S_TRIG: begin
        periph_req_o = 1'b1;
        periph_add_o = BASE_ADDR + TRIG_OFF;
      end
      default: ;
    endcase
  end

  assign busy_o      = (state != S_IDLE);
  assign done_o      = done_q;
  assign error_o     = error_q;
  assign job_id_o    = job_id_q;
  assign periph_be_o = 4'hF;
  assign periph_id_o = ID_WIDTH'(MASTER_ID);
  assign dbg_state_o = state;

endmodule

// File: tb/tb_traffic_gen_cfg_master.sv
// Bench for traffic_gen_cfg_master: randomized config-port slave, transaction scoreboard
// fed from a job-level model, and outcome (done/error) scoreboard with cycle timing.
module tb_traffic_gen_cfg_master;
  localparam int          N_PARAMS    = 16;
  localparam int          ID_WIDTH    = 10;
  localparam int          MASTER_ID   = 1;
  localparam logic [31:0] BASE_ADDR   = 32'h0002_0000;
  localparam int          BACKOFF_CYC = 8;
  localparam int          TIMEOUT_CYC = 100;
  localparam logic [ID_WIDTH-1:0] STRAY_ID = 10'h2A5;

  logic clk, rst_i, start_i, evt_i;
  logic [N_PARAMS*32-1:0] params_i;
  logic busy_o, done_o, error_o;
  logic [7:0] job_id_o;
  logic periph_req_o, periph_gnt_i, periph_wen_o, periph_r_valid_i;
  logic [31:0] periph_add_o, periph_data_o, periph_r_data_i;
  logic [3:0] periph_be_o, dbg_state_o;
  logic [ID_WIDTH-1:0] periph_id_o, periph_r_id_i;

  int n_tests = 0, n_fail = 0, cyc = 0;
  logic [64:0] exp_q[$];   // {is_read, addr, data}
  logic [31:0] acq_q[$];   // ACQUIRE read data to return, in order
  logic [41:0] out_q[$];   // {done, error, job_id, cycle}
  int max_stall = 0, max_rsp = 1;
  bit stray_en = 0;
  bit trig_seen = 0;
  int trig_rsp_cyc = 0, wr_grants = 0, outcomes_seen = 0;

  traffic_gen_cfg_master #(
    .N_PARAMS(N_PARAMS), .ID_WIDTH(ID_WIDTH), .MASTER_ID(MASTER_ID),
    .BASE_ADDR(BASE_ADDR), .BACKOFF_CYC(BACKOFF_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .params_i(params_i), .evt_i(evt_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .job_id_o(job_id_o),
    .periph_req_o(periph_req_o), .periph_gnt_i(periph_gnt_i), .periph_add_o(periph_add_o),
    .periph_wen_o(periph_wen_o), .periph_be_o(periph_be_o), .periph_data_o(periph_data_o),
    .periph_id_o(periph_id_o), .periph_r_data_i(periph_r_data_i),
    .periph_r_valid_i(periph_r_valid_i), .periph_r_id_i(periph_r_id_i),
    .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got still running, expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // slave model + monitor: grants with random stalls, answers 1..max_rsp cycles later
  bit hold = 0, stall_set = 0, outstanding = 0, outst0 = 0, rsp_read = 0, rsp_trig = 0;
  bit after_fail = 0;
  int stall_left = 0, rsp_wait = 0, fail_cyc = 0;
  logic [31:0] h_add, h_data, rsp_data;
  logic h_wen;
  logic [64:0] e;
  logic [41:0] o;

  initial begin : slave_monitor
    periph_gnt_i = 1'b0; periph_r_valid_i = 1'b0;
    periph_r_id_i = ID_WIDTH'(MASTER_ID); periph_r_data_i = '0;
    forever begin
      @(negedge clk);
      periph_gnt_i = 1'b0;
      periph_r_valid_i = 1'b0;
      periph_r_id_i = ID_WIDTH'(MASTER_ID);
      periph_r_data_i = $urandom();

      if (done_o || error_o) begin
        if (out_q.size() == 0) check("unexpected_pulse", {done_o, error_o}, 2'b00);
        else begin
          o = out_q.pop_front();
          check("outcome_kind", {done_o, error_o}, o[41:40]);
          check("outcome_cycle", cyc, o[31:0]);
          if (done_o) check("job_id", job_id_o, o[39:32]);
          check("busy_at_pulse", busy_o, 1'b0);
          outcomes_seen++;
        end
      end

      outst0 = outstanding;
      if (rst_i) begin
        hold = 0; stall_set = 0; after_fail = 0;
      end else begin
        if (hold) begin
          check("req_held", periph_req_o, 1'b1);
          check("stable_add", periph_add_o, h_add);
          check("stable_wen", periph_wen_o, h_wen);
          check("stable_data", periph_data_o, h_data);
        end
        hold = 0;
        if (periph_req_o) begin
          check("one_outstanding", outstanding, 1'b0);
          if (after_fail) begin
            check("backoff_gap", (cyc - fail_cyc - 1) >= BACKOFF_CYC, 1'b1);
            after_fail = 0;
          end
        end
      end

      if (outstanding) begin
        rsp_wait--;
        if (rsp_wait == 0) begin
          periph_r_valid_i = 1'b1;
          periph_r_data_i = rsp_data;
          outstanding = 0;
          if (rsp_trig) begin trig_seen = 1; trig_rsp_cyc = cyc; end
          if (rsp_read && rsp_data == 32'hFFFF_FFFF) begin after_fail = 1; fail_cyc = cyc; end
        end else if (stray_en && $urandom_range(0, 2) == 0) begin
          periph_r_valid_i = 1'b1; periph_r_id_i = STRAY_ID; periph_r_data_i = 32'hFFFF_FFFF;
        end
      end else if (stray_en && $urandom_range(0, 2) == 0) begin
        periph_r_valid_i = 1'b1; periph_r_id_i = STRAY_ID; periph_r_data_i = 32'hFFFF_FFFF;
      end

      if (!rst_i && periph_req_o && !outst0) begin
        if (!stall_set) begin stall_left = $urandom_range(0, max_stall); stall_set = 1; end
        if (stall_left > 0) begin
          stall_left--;
          hold = 1; h_add = periph_add_o; h_wen = periph_wen_o; h_data = periph_data_o;
        end else begin
          periph_gnt_i = 1'b1;
          stall_set = 0;
          if (exp_q.size() == 0) check("unexpected_txn", periph_add_o, 32'hDEAD_BEEF);
          else begin
            e = exp_q.pop_front();
            check("txn_wen", periph_wen_o, e[64]);
            check("txn_addr", periph_add_o, e[63:32]);
            if (!e[64]) check("txn_data", periph_data_o, e[31:0]);
          end
          rsp_read = periph_wen_o;
          rsp_trig = !periph_wen_o && periph_add_o == BASE_ADDR;
          if (!periph_wen_o && periph_add_o >= BASE_ADDR + 32'h40) wr_grants++;
          rsp_data = (periph_wen_o && acq_q.size() > 0) ? acq_q.pop_front() : $urandom();
          outstanding = 1;
          rsp_wait = $urandom_range(1, max_rsp);
        end
      end
    end
  end

  // mode: 0 evt after evt_dly, 1 no evt (timeout), 2 evt on expiry cycle, 3 reset at write 5
  task automatic run_job(input int n_busy, input logic [31:0] acq_val, input int mode,
                         input int evt_dly, input bit evt_in_wr);
    logic [N_PARAMS*32-1:0] p;
    int seen0, target;
    bit pulsed;
    for (int i = 0; i < N_PARAMS; i++) p[32*i +: 32] = $urandom();
    for (int r = 0; r < n_busy; r++) begin
      exp_q.push_back({1'b1, BASE_ADDR + 32'h4, 32'h0});
      acq_q.push_back(32'hFFFF_FFFF);
    end
    exp_q.push_back({1'b1, BASE_ADDR + 32'h4, 32'h0});
    acq_q.push_back(acq_val);
    for (int i = 0; i < N_PARAMS; i++)
      exp_q.push_back({1'b0, BASE_ADDR + 32'h40 + 32'(4 * i), p[32*i +: 32]});
    exp_q.push_back({1'b0, BASE_ADDR, 32'h0});
    trig_seen = 0; wr_grants = 0; pulsed = 0;
    seen0 = outcomes_seen;

    params_i = p; start_i = 1'b1;
    tick;
    start_i = 1'b0; params_i = ~p;
    check("busy_after_start", busy_o, 1'b1);

    if (mode == 3) begin
      for (int k = 0; k < 2000 && wr_grants < 5; k++) tick;
      check("reached_write5", wr_grants >= 5, 1'b1);
      rst_i = 1'b1;
      tick;
      check("rst_req", periph_req_o, 1'b0);
      check("rst_busy", busy_o, 1'b0);
      check("rst_pulses", {done_o, error_o}, 2'b00);
      rst_i = 1'b0;
      exp_q.delete(); acq_q.delete();
      repeat (10) tick;
      check("idle_after_rst", busy_o, 1'b0);
      return;
    end

    for (int k = 0; k < 2000 && !trig_seen; k++) begin
      if (evt_in_wr && !pulsed && wr_grants >= 3) begin
        evt_i = 1'b1; start_i = 1'b1; params_i = {N_PARAMS{32'h1234_5678}};
        pulsed = 1;
        tick;
        evt_i = 1'b0; start_i = 1'b0;
      end else tick;
    end
    check("trig_reached", trig_seen, 1'b1);

    if (mode == 1) out_q.push_back({2'b01, 8'h00, 32'(trig_rsp_cyc + TIMEOUT_CYC + 1)});
    else begin
      target = (mode == 2) ? trig_rsp_cyc + TIMEOUT_CYC : trig_rsp_cyc + evt_dly;
      out_q.push_back({2'b10, acq_val[7:0], 32'(target + 1)});
      for (int k = 0; k < 500 && cyc < target; k++) tick;
      evt_i = 1'b1;
      tick;
      evt_i = 1'b0;
    end
    for (int k = 0; k < 300 && outcomes_seen == seen0; k++) tick;
    check("outcome_seen", outcomes_seen - seen0, 1);
    check("all_txn_seen", exp_q.size(), 0);
    repeat (3) tick;
  endtask

  function automatic logic [31:0] rand_acq();
    logic [31:0] v;
    v = $urandom();
    if (v == 32'hFFFF_FFFF) v = 32'h0000_00FE;
    return v;
  endfunction

  initial begin : driver
    rst_i = 1'b1; start_i = 1'b0; evt_i = 1'b0; params_i = '0;
    repeat (3) tick;
    check("rst_req", periph_req_o, 1'b0);
    check("rst_add", periph_add_o, 32'h0);
    check("rst_wen", periph_wen_o, 1'b0);
    check("rst_data", periph_data_o, 32'h0);
    check("rst_be", periph_be_o, 4'hF);
    check("rst_id", periph_id_o, ID_WIDTH'(MASTER_ID));
    check("rst_busy", busy_o, 1'b0);
    check("rst_done_err", {done_o, error_o}, 2'b00);
    check("rst_job_id", job_id_o, 8'h00);
    rst_i = 1'b0;
    tick;
    evt_i = 1'b1;
    tick;
    evt_i = 1'b0;
    repeat (3) tick;
    check("idle_evt_ignored", busy_o, 1'b0);

    max_stall = 0; max_rsp = 1; stray_en = 0;
    run_job(0, 32'h3, 0, 20, 0);
    run_job(2, 32'h1, 0, 20, 0);

    max_stall = 5; max_rsp = 3;
    for (int j = 0; j < 3; j++)
      run_job($urandom_range(0, 1), rand_acq(), 0, $urandom_range(1, 60), 0);

    run_job(0, 32'h55, 1, 0, 0);
    run_job(0, 32'h77, 2, 0, 0);

    run_job(0, 32'h5, 3, 0, 0);
    run_job(0, 32'h6, 0, 10, 0);

    stray_en = 1;
    run_job(1, 32'hA5, 0, 30, 1);
    stray_en = 0;

    repeat (5) tick;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
